// File: rtl/ce_halt_arbiter_if.sv
// ce_halt_arbiter_if: halt request/grant and clock-enable gate handshake bundle.
interface ce_halt_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0] req_i;
    logic               clock_enable_i;
    logic               trigger_o;
    logic               release_o;
    logic [NUM_REQ-1:0] gnt_o;
    logic               halted_o;
    logic               busy_o;
    logic               timeout_o;
    modport master (
        output req_i, clock_enable_i,
        input  trigger_o, release_o, gnt_o, halted_o, busy_o, timeout_o
    );
    modport slave (
        input  req_i, clock_enable_i,
        output trigger_o, release_o, gnt_o, halted_o, busy_o, timeout_o
    );
endinterface

// File: rtl/ce_halt_arbiter.sv
// ce_halt_arbiter: round-robin sharing of the core clock-enable gate among halt requesters.
// CE_ARB_TIMEOUT_EN adds the MAX_HOLD forced release and the timeout_o pulse.
module ce_halt_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 1024
) (
    input logic             clk,
    input logic             rst_n,
    ce_halt_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [2:0] {IDLE, TRIGGER, WAIT_HALT, HELD, RELEASE, WAIT_RUN} state_t;
    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d, own_q, own_d, win;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               trig_q, trig_d, rel_q, rel_d, halt_q, halt_d, busy_q;
    logic               force_rel;
    int                 j;
    // Smallest offset from last_q+1 is assigned last, so it wins
    always_comb begin
        win = '0;
        j = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = int'(last_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.req_i[IW'(j)]) win = IW'(j);
        end
    end
`ifdef CE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    assign force_rel = cnt_q == CW'(MAX_HOLD - 1);
    always_comb begin
        cnt_d = state_q == WAIT_HALT ? '0 : (state_q == HELD && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        to_d  = state_q == HELD && force_rel && bus.req_i[own_q];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
    assign bus.timeout_o = to_q;
`else
    assign force_rel     = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        gnt_d   = gnt_q;
        trig_d  = 1'b0;
        rel_d   = 1'b0;
        halt_d  = halt_q;
        case (state_q)
            IDLE: if (|bus.req_i) begin
                state_d = TRIGGER;
                own_d   = win;
                gnt_d   = NUM_REQ'(1) << win;
                trig_d  = 1'b1;
            end
            TRIGGER:   state_d = WAIT_HALT;
            WAIT_HALT: if (!bus.clock_enable_i) begin
                state_d = HELD;
                halt_d  = 1'b1;
            end
            HELD: if (!bus.req_i[own_q] || force_rel) begin
                state_d = RELEASE;
                rel_d   = 1'b1;
                halt_d  = 1'b0;
            end
            RELEASE:  state_d = WAIT_RUN;
            WAIT_RUN: if (bus.clock_enable_i) begin
                state_d = IDLE;
                last_d  = own_q;
                gnt_d   = '0;
            end
            default:  state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            own_q   <= '0;
            gnt_q   <= '0;
            trig_q  <= 1'b0;
            rel_q   <= 1'b0;
            halt_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            gnt_q   <= gnt_d;
            trig_q  <= trig_d;
            rel_q   <= rel_d;
            halt_q  <= halt_d;
            busy_q  <= state_d != IDLE;
        end
    end
    assign bus.trigger_o = trig_q;
    assign bus.release_o = rel_q;
    assign bus.gnt_o     = gnt_q;
    assign bus.halted_o  = halt_q;
    assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_ce_halt_arbiter.sv
// tb_ce_halt_arbiter: directed checks of ce_halt_arbiter against a delayed clock-enable gate model.
module tb_ce_halt_arbiter;
    localparam int N  = 4;
    localparam int MH = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    ce_halt_arbiter_if #(.NUM_REQ(N)) bus();
    ce_halt_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_tests = 0, n_fail = 0;
    int dly_h = 2, dly_r = 3, hc, rc;
    int n_trig = 0, n_rel = 0, n_halt = 0, n_to = 0, n_both = 0, n_idle = 0;
    int t0, r0, h0, b0, o0, i0;
    // Gate model: CE falls dly_h cycles after a trigger, rises dly_r cycles after a release
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.clock_enable_i <= 1'b1;
            hc <= 0;
            rc <= 0;
        end else begin
            if (bus.trigger_o) hc <= dly_h;
            else if (hc > 0) begin
                hc <= hc - 1;
                if (hc == 1) bus.clock_enable_i <= 1'b0;
            end
            if (bus.release_o) rc <= dly_r;
            else if (rc > 0) begin
                rc <= rc - 1;
                if (rc == 1) bus.clock_enable_i <= 1'b1;
            end
        end
    end
    always @(negedge clk) begin
        if (rst_n) begin
            n_trig += int'(bus.trigger_o);
            n_rel  += int'(bus.release_o);
            n_halt += int'(bus.halted_o);
            n_to   += int'(bus.timeout_o);
            n_both += int'(bus.release_o & bus.timeout_o);
            n_idle += int'(!bus.busy_o);
        end
    end
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic logic [31:0] outs();
        return 32'({bus.trigger_o, bus.release_o, bus.gnt_o, bus.halted_o, bus.busy_o, bus.timeout_o});
    endfunction
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    function automatic bit cond(input int sel);
        return (sel == 0 && bus.halted_o) || (sel == 1 && !bus.busy_o) ||
               (sel == 2 && !bus.halted_o) || (sel == 3 && bus.trigger_o);
    endfunction
    task automatic wait_for(input string tag, input int sel, input int budget);
        int k = 0;
        while (!cond(sel) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!cond(sel)) chk({tag, " wait"}, 32'd0, 32'd1);
    endtask
    task automatic do_reset();
        bus.req_i = '0;
        rst_n = 1'b0;
        cyc(3);
        chk("reset outs", outs(), 32'd0);
        chk("reset ce", 32'(bus.clock_enable_i), 32'd1);
        rst_n = 1'b1;
        cyc(1);
    endtask
    task automatic snap();
        t0 = n_trig; r0 = n_rel; h0 = n_halt; b0 = n_both; o0 = n_to;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        bus.req_i = '0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("idle outs", outs(), 32'd0);
            cyc(1);
        end
        snap();
        dly_h = 128;
        bus.req_i = 4'b0001;
        wait_for("single halt", 0, 300);
        chk("single gnt", 32'(bus.gnt_o), 32'h1);
        cyc(19);
        bus.req_i = 4'b0000;
        wait_for("single idle", 1, 50);
        chk("single halted cycles", 32'(n_halt - h0), 32'd20);
        chk("single trig pulses", 32'(n_trig - t0), 32'd1);
        chk("single rel pulses", 32'(n_rel - r0), 32'd1);
        chk("single idle gnt", 32'(bus.gnt_o), 32'd0);
        chk("single idle ce", 32'(bus.clock_enable_i), 32'd1);
        do_reset();
        dly_h = 2;
        bus.req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_for("rr halt", 0, 50);
            chk("rr gnt", 32'(bus.gnt_o), 32'd1 << (k % 4));
            bus.req_i = 4'b1111 & ~bus.gnt_o;
            wait_for("rr rel", 2, 20);
            bus.req_i = 4'b1111;
        end
        bus.req_i = 4'b0000;
        wait_for("rr idle", 1, 50);
        snap();
        dly_h = 5;
        bus.req_i = 4'b0001;
        wait_for("early trig", 3, 20);
        cyc(1);
        bus.req_i = 4'b0000;
        wait_for("early idle", 1, 50);
        chk("early halted cycles", 32'(n_halt - h0), 32'd1);
        chk("early rel pulses", 32'(n_rel - r0), 32'd1);
        chk("early trig pulses", 32'(n_trig - t0), 32'd1);
        bus.req_i = 4'b0001;
        wait_for("busy halt", 0, 50);
        chk("busy gnt", 32'(bus.gnt_o), 32'h1);
        bus.req_i = 4'b0011;
        cyc(5);
        chk("nonowner gnt", 32'(bus.gnt_o), 32'h1);
        chk("nonowner halted", 32'(bus.halted_o), 32'd1);
        i0 = n_idle;
        bus.req_i = 4'b0010;
        wait_for("handoff rel", 2, 20);
        wait_for("handoff halt", 0, 50);
        chk("handoff gnt", 32'(bus.gnt_o), 32'h2);
        chk("handoff idle cycles", 32'(n_idle - i0), 32'd1);
        bus.req_i = 4'b0000;
        wait_for("handoff idle", 1, 50);
`ifndef CE_ARB_TIMEOUT_EN
        snap();
        bus.req_i = 4'b0001;
        wait_for("long halt", 0, 50);
        cyc(40);
        chk("long halted", 32'(bus.halted_o), 32'd1);
        chk("long no timeout", 32'(n_to - o0), 32'd0);
        chk("long no release", 32'(n_rel - r0), 32'd0);
        bus.req_i = 4'b0000;
        wait_for("long idle", 1, 50);
`else
        do_reset();
        snap();
        bus.req_i = 4'b0011;
        wait_for("to halt", 0, 50);
        chk("to gnt", 32'(bus.gnt_o), 32'h1);
        wait_for("to rel", 2, 40);
        cyc(1);
        chk("to halted cycles", 32'(n_halt - h0), 32'd16);
        chk("to rel with timeout", 32'(n_both - b0), 32'd1);
        chk("to pulses", 32'(n_to - o0), 32'd1);
        wait_for("to next halt", 0, 50);
        chk("to next gnt", 32'(bus.gnt_o), 32'h2);
        bus.req_i = 4'b0010;
        wait_for("to single rel", 2, 40);
        wait_for("to single halt", 0, 50);
        chk("to regrant gnt", 32'(bus.gnt_o), 32'h2);
        bus.req_i = 4'b0000;
        wait_for("to idle", 1, 60);
`endif
        bus.req_i = 4'b0001;
        wait_for("midrst halt", 0, 50);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst outs", outs(), 32'd0);
        chk("midrst ce", 32'(bus.clock_enable_i), 32'd1);
        bus.req_i = 4'b0000;
        rst_n = 1'b1;
        cyc(2);
        chk("post reset outs", outs(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
